cpu_commit: RTL
===============

Name: cpu_commit

Overview:
- Writeback/commit stage directly downstream of the execute ALU functions.
- Each cycle it consumes one EXECUTE result and updates all architectural state:
  - general register file
  - 64-word data memory
  - pc and the interrupt special registers
  - a one-byte UART transmit buffer and a receive latch with interrupt pending flag
- It also provides the register, memory and special-register read values that decode packs into DECODE for the next instruction.

Parameters:
- NREG, 16, number of general registers; x0 reads as zero and ignores writes.
- MEM_WORDS, 64, data memory depth; fixed to match the 6-bit mem_addr.
- PC_RESET, 32'd0, pc value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ex_valid  in  1  an EXECUTE result is presented.
- ex_ready  out  1  the result is committed this cycle.
- ex  in  EXECUTE  result record: pc, w_req, w_data, ack, w_rd, x_rd, mem_addr, mem_val, intr_en, intr_pc, intr_vec.
- rd_idx  in  log2(NREG)  destination register of the presented instruction.
- rs1_idx, rs2_idx  in  log2(NREG)  decode read indices.
- mem_raddr  in  6  decode memory read address.
- x_rs1, x_rs2  out  32  combinational register reads; index 0 reads 0.
- mem_val  out  32  combinational mem[mem_raddr].
- pc, intr_pc, intr_vec  out  32  special registers.
- intr_en  out  1  special register.
- w_busy  out  32  zero-extended tx_valid.
- r_data  out  32  zero-extended last received byte.
- intr_req  out  1  rx_pending & intr_en.
- tx_valid  out  1  tx byte available.
- tx_data  out  8  tx byte.
- tx_ready  in  1  UART accepts the byte.
- rx_valid  in  1  one-cycle pulse: byte received.
- rx_data  in  8  received byte.

Behaviour:
- Reset (async, immediate on rst):
  - pc = PC_RESET.
  - intr_en, intr_pc, intr_vec = 0.
  - all registers = 0; all memory words = 0.
  - tx_valid = 0, tx_data = 0, r_data = 0, rx_pending = 0.
  - state = RUN.
  - Reset mid-stall discards the held instruction.
- Commit occurs when ex_valid & ex_ready at a rising edge. A commit writes, at that edge:
  - pc <= ex.pc.
  - intr_en/intr_pc/intr_vec <= ex fields.
  - mem[ex.mem_addr] <= ex.mem_val, unconditionally. Non-store instructions carry the current value back, so this is harmless.
  - reg[rd_idx] <= ex.x_rd if ex.w_rd and rd_idx != 0.
  - if ex.w_req: tx_data <= ex.w_data, tx_valid <= 1.
  - if ex.ack: rx_pending <= 0.
- Without a commit, all architectural state holds.
- Read ports are combinational from current state; there is no write-through bypass. A value written at edge N is visible after edge N.
- TX buffer:
  - tx_valid & tx_ready at an edge clears tx_valid, unless a commit with w_req loads a new byte at the same edge; the new byte wins.
- RX path:
  - rx_valid at an edge sets r_data <= rx_data and rx_pending <= 1.
  - If rx_valid and an ack commit occur at the same edge, rx_pending ends at 1.
  - A byte arriving while rx_pending is already set overwrites r_data; there is no overrun flag.
- FSM, two states, registered:
  - RUN:
    - ex_ready = !(ex_valid & ex.w_req & tx_valid & !tx_ready).
    - If ex_valid & ex.w_req & tx_valid & !tx_ready, go to WAIT_TX.
  - WAIT_TX:
    - ex_ready = 0.
    - Stay until tx_ready is seen at an edge, which clears tx_valid; then go to RUN.
    - The held instruction commits in the following RUN cycle, giving exactly one bubble after the drain.
  - The upstream stage must hold ex and rd_idx stable while ex_ready = 0.
- Arithmetic: none. All fields are copied; w_busy and r_data are zero-extended to 32 bits.

Decomposition:
- The EXECUTE/DECODE typedefs stay in the existing CPU package.
- Add to that package:
  - COMMIT_STATE enum {RUN, WAIT_TX}.
  - MEM_WORDS and NREG constants.
- One natural sub-module, cpu_regfile: NREG x 32, two combinational read ports, one write port, x0 hardwired to zero, async reset clear.
- Memory, special registers, UART buffers and the FSM live in cpu_commit.

Test Plan:
- Reset, then ex_valid with w_rd=1, rd_idx=3, x_rd=32'h1234, pc=1 -> next cycle x_rs1 (rs1_idx=3) = 32'h1234 and pc = 1. Same with rd_idx=0 -> x_rs1 (rs1_idx=0) stays 0.
- Commit mem_addr=6'd63, mem_val=32'hDEADBEEF -> mem_raddr=63 reads DEADBEEF and mem_raddr=0 reads 0.
- Back-to-back w_req commits, w_data 8'h41 then 8'h42, with tx_ready held 0:
  - first commits and tx_valid=1, tx_data=41, w_busy=1.
  - second sees ex_ready=0 and the FSM enters WAIT_TX.
  - raise tx_ready for 1 cycle -> one bubble, then 42 commits and tx_data=42.
- rx_valid with rx_data=8'h5A while intr_en=1 -> r_data=32'h5A, intr_req=1. Commit ack=1 -> intr_req=0. Repeat with rx_valid coincident with the ack commit -> intr_req remains 1.
- Commit a record with intr_en=0, intr_pc=32'd7, intr_vec=32'd20, pc=32'd20 (icall-style) -> outputs match and intr_req is masked despite rx_pending=1.
- Assert rst while in WAIT_TX with tx_valid=1 -> all outputs return to reset values immediately, ex_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/cpu_commit_pkg.sv
// Shared CPU types for the commit stage.
//   execute_t      : result record produced by the execute stage
//   decode_t       : read values that decode packs for the next instruction
//   commit_state_e : commit-stage flow-control state
//   NREG/MEM_WORDS : default register-file and data-memory depths
package cpu_commit_pkg;

  localparam int NREG      = 16;
  localparam int MEM_WORDS = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic        w_req;     // write a byte to the UART tx buffer
    logic [7:0]  w_data;
    logic        ack;       // acknowledge the pending rx interrupt
    logic        w_rd;      // write x_rd to the destination register
    logic [31:0] x_rd;
    logic [5:0]  mem_addr;
    logic [31:0] mem_val;   // always written; non-stores carry the old value
    logic        intr_en;
    logic [31:0] intr_pc;
    logic [31:0] intr_vec;
  } execute_t;

  typedef struct packed {
    logic [31:0] x_rs1;
    logic [31:0] x_rs2;
    logic [31:0] mem_val;
    logic [31:0] pc;
    logic        intr_en;
    logic [31:0] intr_pc;
    logic [31:0] intr_vec;
    logic [31:0] w_busy;
    logic [31:0] r_data;
  } decode_t;

  typedef enum logic {
    RUN,
    WAIT_TX
  } commit_state_e;

endpackage

// File: rtl/cpu_regfile.sv
// General register file: NREG x 32 bits, x0 hardwired to zero.
//   clk, rst         : clock, asynchronous active-high reset (clears all)
//   we/waddr/wdata   : single write port, writes to index 0 are dropped
//   raddr1/rdata1    : combinational read port 1
//   raddr2/rdata2    : combinational read port 2
module cpu_regfile #(
  parameter int  NREG = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [31:0]   rdata1,
  output logic [31:0]   rdata2
);

  logic [31:0] regs [NREG];

  // NOTE: every state element is updated with <= so all flops sample the
  // pre-edge values; blocking assignments here would create order races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // No bypass: a write becomes visible only after its clock edge.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_commit.sv
// Writeback/commit stage. Consumes one execute result per cycle and updates
// the register file, 64-word data memory, pc, interrupt registers and the
// UART tx/rx buffers; provides combinational read values for decode.
//   clk, rst                    : clock, asynchronous active-high reset
//   ex_valid/ex_ready/ex/rd_idx : execute result handshake and record
//   rs1_idx/rs2_idx/mem_raddr   : decode read addresses
//   x_rs1/x_rs2/mem_val         : combinational register/memory reads
//   pc/intr_en/intr_pc/intr_vec : special registers
//   w_busy/r_data/intr_req      : UART status seen by the program
//   tx_valid/tx_data/tx_ready   : UART transmit handshake
//   rx_valid/rx_data            : UART receive strobe and byte
module cpu_commit
  import cpu_commit_pkg::*;
#(
  parameter int          NREG      = 16,
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] PC_RESET  = 32'd0,
  localparam int         AW        = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  execute_t      ex,
  input  logic [AW-1:0] rd_idx,
  input  logic [AW-1:0] rs1_idx,
  input  logic [AW-1:0] rs2_idx,
  input  logic [5:0]    mem_raddr,
  output logic [31:0]   x_rs1,
  output logic [31:0]   x_rs2,
  output logic [31:0]   mem_val,
  output logic [31:0]   pc,
  output logic [31:0]   intr_pc,
  output logic [31:0]   intr_vec,
  output logic          intr_en,
  output logic [31:0]   w_busy,
  output logic [31:0]   r_data,
  output logic          intr_req,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data
);

  commit_state_e state, state_next;
  logic          commit;
  logic          tx_blocked;
  logic [7:0]    r_byte;
  logic          rx_pending;
  logic [31:0]   mem [MEM_WORDS];

  // A new tx byte cannot be accepted while the old one is still unsent.
  assign tx_blocked = ex_valid && ex.w_req && tx_valid && !tx_ready;
  assign commit     = ex_valid && ex_ready;

  // NOTE: defaults are assigned before the case so every path drives every
  // output; a missing assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    ex_ready   = 1'b0;
    unique case (state)
      RUN: begin
        ex_ready = !tx_blocked;
        if (tx_blocked) state_next = WAIT_TX;
      end
      // The drain edge returns to RUN; the held instruction commits in the
      // following cycle, giving one bubble.
      WAIT_TX: begin
        if (tx_ready) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  cpu_regfile #(.NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (commit && ex.w_rd),
    .waddr  (rd_idx),
    .wdata  (ex.x_rd),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (x_rs1),
    .rdata2 (x_rs2)
  );

  // NOTE: the data memory is cleared on reset, so it is built from flops
  // rather than a RAM macro; that is required for the all-zero reset image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[ex.mem_addr] <= ex.mem_val;
    end
  end

  assign mem_val = mem[mem_raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= PC_RESET;
      intr_en  <= 1'b0;
      intr_pc  <= '0;
      intr_vec <= '0;
    end else if (commit) begin
      pc       <= ex.pc;
      intr_en  <= ex.intr_en;
      intr_pc  <= ex.intr_pc;
      intr_vec <= ex.intr_vec;
    end
  end

  // A newly committed byte takes priority over the drain of the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (commit && ex.w_req) begin
      tx_valid <= 1'b1;
      tx_data  <= ex.w_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  // An arriving byte wins over an ack, so no interrupt is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte     <= '0;
      rx_pending <= 1'b0;
    end else if (rx_valid) begin
      r_byte     <= rx_data;
      rx_pending <= 1'b1;
    end else if (commit && ex.ack) begin
      rx_pending <= 1'b0;
    end
  end

  assign w_busy   = {31'd0, tx_valid};
  assign r_data   = {24'd0, r_byte};
  assign intr_req = rx_pending && intr_en;

endmodule
